// File: rtl/band_bar_scanner.sv
// Sweeps the spectrum band buffer once per frame and streams saturated bar
// heights over AXI-Stream, tracking the loudest band and dropped frames.
module band_bar_scanner #(
    parameter int BANDS      = 32,
    parameter int DATA_WIDTH = 16,
    parameter int SHIFT      = 10,
    parameter int BAR_WIDTH  = 6,
    parameter int BAR_MAX    = 47
) (
    input  logic                       clk_50m,
    input  logic                       rst_n,
    input  logic                       scan_en,
    input  logic                       frame_stb,
    output logic [$clog2(BANDS)-1:0]   rd_addr,
    output logic                       rd_en,
    input  logic [DATA_WIDTH-1:0]      rd_data,
    input  logic                       rd_data_valid,
    output logic                       m_axis_tvalid,
    input  logic                       m_axis_tready,
    output logic [BAR_WIDTH-1:0]       m_axis_tdata,
    output logic                       m_axis_tlast,
    output logic [$clog2(BANDS)-1:0]   peak_band,
    output logic [DATA_WIDTH-1:0]      peak_value,
    output logic                       peak_stb,
    output logic [7:0]                 drop_cnt,
    output logic                       busy
);

    localparam int AW = $clog2(BANDS);
    localparam logic [AW-1:0]         LAST_BAND = AW'(BANDS - 1);
    localparam logic [DATA_WIDTH-1:0] CEIL      = DATA_WIDTH'(BAR_MAX);
    localparam logic [BAR_WIDTH-1:0]  CEIL_BAR  = BAR_WIDTH'(BAR_MAX);

    typedef enum logic [1:0] {
        IDLE,
        RD,
        WAIT,
        OUT
    } state_t;

    state_t                  state_q, state_d;
    logic                    pending_q, pending_d;
    logic [AW-1:0]           addr_q, addr_d;
    logic [DATA_WIDTH-1:0]   max_val_q, max_val_d;
    logic [AW-1:0]           max_band_q, max_band_d;
    logic                    rd_en_q, rd_en_d;
    logic [AW-1:0]           rd_addr_q, rd_addr_d;
    logic                    tvalid_q, tvalid_d;
    logic [BAR_WIDTH-1:0]    tdata_q, tdata_d;
    logic                    tlast_q, tlast_d;
    logic [AW-1:0]           peak_band_q, peak_band_d;
    logic [DATA_WIDTH-1:0]   peak_value_q, peak_value_d;
    logic                    peak_stb_q, peak_stb_d;
    logic [7:0]              drop_q, drop_d;
    logic                    busy_q, busy_d;

    logic                    start;
    logic                    strobe;
    logic [DATA_WIDTH-1:0]   scaled;
    logic [BAR_WIDTH-1:0]    bar;

    assign start  = (state_q == IDLE) && pending_q;
    assign strobe = frame_stb && scan_en;
    assign scaled = rd_data >> SHIFT;
    assign bar    = (scaled > CEIL) ? CEIL_BAR : scaled[BAR_WIDTH-1:0];

    always_comb begin
        state_d      = state_q;
        pending_d    = pending_q;
        addr_d       = addr_q;
        max_val_d    = max_val_q;
        max_band_d   = max_band_q;
        rd_en_d      = 1'b0;
        rd_addr_d    = rd_addr_q;
        tvalid_d     = tvalid_q;
        tdata_d      = tdata_q;
        tlast_d      = tlast_q;
        peak_band_d  = peak_band_q;
        peak_value_d = peak_value_q;
        peak_stb_d   = 1'b0;
        drop_d       = drop_q;

        // A strobe landing on the consuming cycle re-arms without a drop.
        if (start) begin
            pending_d = 1'b0;
        end
        if (strobe) begin
            if (pending_q && !start && (drop_q != 8'hff)) begin
                drop_d = drop_q + 8'd1;
            end
            pending_d = 1'b1;
        end

        unique case (state_q)
            IDLE: begin
                if (pending_q) begin
                    state_d    = RD;
                    addr_d     = '0;
                    max_val_d  = '0;
                    max_band_d = '0;
                    rd_en_d    = 1'b1;
                    rd_addr_d  = '0;
                end
            end
            RD: begin
                state_d = WAIT;
            end
            WAIT: begin
                if (rd_data_valid) begin
                    tdata_d  = bar;
                    tlast_d  = (addr_q == LAST_BAND);
                    tvalid_d = 1'b1;
                    state_d  = OUT;
                    if (rd_data > max_val_q) begin
                        max_val_d  = rd_data;
                        max_band_d = addr_q;
                    end
                end
            end
            OUT: begin
                if (m_axis_tready) begin
                    tvalid_d = 1'b0;
                    tlast_d  = 1'b0;
                    if (addr_q == LAST_BAND) begin
                        peak_band_d  = max_band_q;
                        peak_value_d = max_val_q;
                        peak_stb_d   = 1'b1;
                        state_d      = IDLE;
                    end else begin
                        addr_d    = addr_q + 1'b1;
                        rd_en_d   = 1'b1;
                        rd_addr_d = addr_q + 1'b1;
                        state_d   = RD;
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge clk_50m or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            pending_q    <= 1'b0;
            addr_q       <= '0;
            max_val_q    <= '0;
            max_band_q   <= '0;
            rd_en_q      <= 1'b0;
            rd_addr_q    <= '0;
            tvalid_q     <= 1'b0;
            tdata_q      <= '0;
            tlast_q      <= 1'b0;
            peak_band_q  <= '0;
            peak_value_q <= '0;
            peak_stb_q   <= 1'b0;
            drop_q       <= '0;
            busy_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            pending_q    <= pending_d;
            addr_q       <= addr_d;
            max_val_q    <= max_val_d;
            max_band_q   <= max_band_d;
            rd_en_q      <= rd_en_d;
            rd_addr_q    <= rd_addr_d;
            tvalid_q     <= tvalid_d;
            tdata_q      <= tdata_d;
            tlast_q      <= tlast_d;
            peak_band_q  <= peak_band_d;
            peak_value_q <= peak_value_d;
            peak_stb_q   <= peak_stb_d;
            drop_q       <= drop_d;
            busy_q       <= busy_d;
        end
    end

    assign rd_en         = rd_en_q;
    assign rd_addr       = rd_addr_q;
    assign m_axis_tvalid = tvalid_q;
    assign m_axis_tdata  = tdata_q;
    assign m_axis_tlast  = tlast_q;
    assign peak_band     = peak_band_q;
    assign peak_value    = peak_value_q;
    assign peak_stb      = peak_stb_q;
    assign drop_cnt      = drop_q;
    assign busy          = busy_q;

endmodule

// File: tb/tb_band_bar_scanner.sv
// Bench for band_bar_scanner: buffer model, beat scoreboard, frame table
// and hand-written overrun / scan_en / reset sequences.
module tb_band_bar_scanner;

    localparam int BANDS = 32;
    localparam int AW    = 5;

    logic        clk_50m = 1'b0;
    logic        rst_n = 1'b0;
    logic        scan_en = 1'b0;
    logic        frame_stb = 1'b0;
    logic [AW-1:0] rd_addr;
    logic        rd_en;
    logic [15:0] rd_data = '0;
    logic        rd_data_valid = 1'b0;
    logic        m_axis_tvalid;
    logic        m_axis_tready = 1'b1;
    logic [5:0]  m_axis_tdata;
    logic        m_axis_tlast;
    logic [AW-1:0] peak_band;
    logic [15:0] peak_value;
    logic        peak_stb;
    logic [7:0]  drop_cnt;
    logic        busy;

    band_bar_scanner dut (
        .clk_50m       (clk_50m),
        .rst_n         (rst_n),
        .scan_en       (scan_en),
        .frame_stb     (frame_stb),
        .rd_addr       (rd_addr),
        .rd_en         (rd_en),
        .rd_data       (rd_data),
        .rd_data_valid (rd_data_valid),
        .m_axis_tvalid (m_axis_tvalid),
        .m_axis_tready (m_axis_tready),
        .m_axis_tdata  (m_axis_tdata),
        .m_axis_tlast  (m_axis_tlast),
        .peak_band     (peak_band),
        .peak_value    (peak_value),
        .peak_stb      (peak_stb),
        .drop_cnt      (drop_cnt),
        .busy          (busy)
    );

    always #5 clk_50m = ~clk_50m;

    typedef struct {
        string name;
        int    pat;
        int    rdy;
        int    exp_band;
        int    exp_val;
    } vec_t;

    vec_t        vecs [6];
    logic [15:0] mem [BANDS];
    logic [6:0]  sb_q [$];
    int          total = 0;
    int          bad = 0;
    int          beats = 0;
    int          rd_cnt = 0;
    int          pk_cnt = 0;
    bit          sb_on = 1'b1;
    int          rdy_mode = 0;
    bit          hold = 1'b0;
    logic [6:0]  held = '0;

    task automatic check(input string nm, input longint act, input longint exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    function automatic int bar_of(input int v);
        int s;
        s = v >> 10;
        return (s > 47) ? 47 : s;
    endfunction

    // Band buffer: synchronous read, data one cycle after rd_en.
    always @(posedge clk_50m) begin
        rd_data_valid <= rd_en;
        if (rd_en) rd_data <= mem[rd_addr];
    end

    initial begin
        forever begin
            @(posedge clk_50m);
            #1;
            m_axis_tready = (rdy_mode == 0) ? 1'b1 : 1'($urandom_range(0, 1));
        end
    end

    always @(negedge clk_50m) begin
        if (rst_n) begin
            if (rd_en) rd_cnt++;
            if (peak_stb) pk_cnt++;
            if (hold) begin
                check("hold_tvalid", m_axis_tvalid, 1);
                if (m_axis_tvalid)
                    check("hold_stable", {m_axis_tlast, m_axis_tdata}, held);
            end
            if (m_axis_tvalid && m_axis_tready) begin
                beats++;
                if (sb_on) begin
                    if (sb_q.size() == 0) begin
                        total++;
                        bad++;
                        $display("FAIL extra_beat: got %0d expected none",
                                 {m_axis_tlast, m_axis_tdata});
                    end else begin
                        check("beat", {m_axis_tlast, m_axis_tdata}, sb_q.pop_front());
                    end
                end
            end
            hold = m_axis_tvalid && !m_axis_tready;
            held = {m_axis_tlast, m_axis_tdata};
        end else begin
            hold = 1'b0;
        end
    end

    task automatic set_mem(input int pat);
        for (int k = 0; k < BANDS; k++) begin
            case (pat)
                0: mem[k] = 16'(k * 1024);
                1: mem[k] = (k == 5) ? 16'hffff : 16'd100;
                2: mem[k] = 16'd500;
                3: mem[k] = (k == 7 || k == 20) ? 16'd40000 : 16'(k * 10);
                4: mem[k] = 16'd0;
                default: mem[k] = 16'((k * 7919) % 65536);
            endcase
        end
    endtask

    task automatic push_frame();
        for (int k = 0; k < BANDS; k++)
            sb_q.push_back({(k == BANDS - 1), 6'(bar_of(int'(mem[k])))});
    endtask

    task automatic strobe();
        @(posedge clk_50m);
        #1 frame_stb = 1'b1;
        @(posedge clk_50m);
        #1 frame_stb = 1'b0;
    endtask

    task automatic wait_quiet(input int bound);
        int n;
        int q;
        n = 0;
        q = 0;
        while (q < 3 && n < bound) begin
            @(posedge clk_50m);
            #1;
            n++;
            q = busy ? 0 : q + 1;
        end
        if (q < 3) begin
            total++;
            bad++;
            $display("FAIL idle_timeout: got busy after %0d cycles expected idle", n);
        end
    endtask

    task automatic run_frame(input int pat, input int rdy, input int eb, input int ev);
        int b0;
        int r0;
        int p0;
        int lat;
        set_mem(pat);
        rdy_mode = rdy;
        push_frame();
        b0 = beats;
        r0 = rd_cnt;
        p0 = pk_cnt;
        strobe();
        lat = 1;
        while (!rd_en && lat < 10) begin
            @(posedge clk_50m);
            #1 lat++;
        end
        check("first_rd_lat", lat, 2);
        check("first_rd_addr", rd_addr, 0);
        wait_quiet(4000);
        check("beat_count", beats - b0, 32);
        check("rd_count", rd_cnt - r0, 32);
        check("peak_stb_count", pk_cnt - p0, 1);
        check("peak_band", peak_band, eb);
        check("peak_value", peak_value, ev);
        check("sb_left", sb_q.size(), 0);
        rdy_mode = 0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got no finish expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int b0;
        int p0;
        int r0;
        int n;
        bit any_busy;

        vecs[0] = '{"ramp",      0, 0, 31, 31744};
        vecs[1] = '{"sat5",      1, 0, 5,  65535};
        vecs[2] = '{"ramp_rand", 0, 1, 31, 31744};
        vecs[3] = '{"tie_flat",  2, 0, 0,  500};
        vecs[4] = '{"tie_pair",  3, 1, 7,  40000};
        vecs[5] = '{"zeros",     4, 0, 0,  0};

        repeat (3) @(posedge clk_50m);
        #1;
        check("rst_outs", {m_axis_tvalid, m_axis_tlast, m_axis_tdata, rd_en,
                           rd_addr, busy, peak_stb, peak_band}, 0);
        check("rst_peak_value", peak_value, 0);
        check("rst_drop", drop_cnt, 0);
        rst_n = 1'b1;
        scan_en = 1'b1;

        foreach (vecs[i])
            run_frame(vecs[i].pat, vecs[i].rdy, vecs[i].exp_band, vecs[i].exp_val);
        run_frame(5, 1, 8, 63352);

        // Strobes while scan_en is low are ignored.
        scan_en = 1'b0;
        r0 = rd_cnt;
        strobe();
        any_busy = 1'b0;
        repeat (10) begin
            @(posedge clk_50m);
            #1 any_busy |= busy;
        end
        check("scan_off_rd", rd_cnt - r0, 0);
        check("scan_off_busy", any_busy, 0);

        // A pending strobe survives scan_en dropping.
        scan_en = 1'b1;
        set_mem(1);
        push_frame();
        push_frame();
        b0 = beats;
        p0 = pk_cnt;
        strobe();
        repeat (20) @(posedge clk_50m);
        strobe();
        scan_en = 1'b0;
        wait_quiet(8000);
        check("pend_beats", beats - b0, 64);
        check("pend_peaks", pk_cnt - p0, 2);
        check("pend_drop", drop_cnt, 0);
        scan_en = 1'b1;

        // Three strobes inside one sweep: one extra sweep, two drops.
        set_mem(0);
        push_frame();
        push_frame();
        b0 = beats;
        p0 = pk_cnt;
        strobe();
        repeat (10) @(posedge clk_50m);
        strobe();
        repeat (5) @(posedge clk_50m);
        strobe();
        repeat (5) @(posedge clk_50m);
        strobe();
        wait_quiet(8000);
        check("ovr_beats", beats - b0, 64);
        check("ovr_peaks", pk_cnt - p0, 2);
        check("ovr_drop", drop_cnt, 2);
        check("ovr_sb_left", sb_q.size(), 0);

        // Continuous strobing saturates the drop counter.
        sb_on = 1'b0;
        @(posedge clk_50m);
        #1 frame_stb = 1'b1;
        repeat (300) @(posedge clk_50m);
        #1 frame_stb = 1'b0;
        wait_quiet(8000);
        check("drop_sat", drop_cnt, 255);
        sb_on = 1'b1;

        // Reset at band 10 aborts the sweep immediately.
        set_mem(0);
        push_frame();
        strobe();
        n = 0;
        while (!(rd_en && rd_addr == 5'd10) && n < 1000) begin
            @(posedge clk_50m);
            #1 n++;
        end
        check("reach_band10", rd_addr, 10);
        #2 rst_n = 1'b0;
        #1;
        check("rst_mid_outs", {m_axis_tvalid, m_axis_tlast, m_axis_tdata, rd_en,
                               busy, peak_stb}, 0);
        check("rst_mid_drop", drop_cnt, 0);
        check("rst_mid_peak", peak_value, 0);
        sb_q.delete();
        repeat (2) @(posedge clk_50m);
        #1 rst_n = 1'b1;
        run_frame(0, 0, 31, 31744);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/band_bar_scanner.md
Name: band_bar_scanner

Overview:
- Read-side consumer of the spectrum band buffer.
- On each frame strobe it sweeps band addresses 0..BANDS-1 through the buffer's synchronous read port (rd_addr/rd_en in, rd_data/rd_data_valid back one cycle later).
- Each magnitude is scaled to a saturated bar height and emitted on an AXI-Stream master, with tlast on the last band.
- Also reports the loudest band of each frame and counts frames lost to overrun. Feeds the bar-graph renderer.

Parameters:
BANDS, 32, number of bands per frame (power of two, >=2)
DATA_WIDTH, 16, band magnitude width
SHIFT, 10, right-shift applied to magnitude before saturation
BAR_WIDTH, 6, bar height output width
BAR_MAX, 47, saturation ceiling for bar height (must be < 2**BAR_WIDTH)

Ports:
clk_50m  in  1  system clock
rst_n  in  1  asynchronous active-low reset
scan_en  in  1  1 = accept frame strobes; 0 = ignore new strobes (an active sweep completes)
frame_stb  in  1  one-cycle pulse: new frame available in band buffer
rd_addr  out  $clog2(BANDS)  band buffer read address
rd_en  out  1  band buffer read request
rd_data  in  DATA_WIDTH  band buffer read data, valid when rd_data_valid
rd_data_valid  in  1  asserted exactly one cycle after rd_en
m_axis_tvalid  out  1  bar height valid
m_axis_tready  in  1  downstream ready
m_axis_tdata  out  BAR_WIDTH  bar height
m_axis_tlast  out  1  high with the band BANDS-1 beat
peak_band  out  $clog2(BANDS)  index of largest magnitude in last completed frame
peak_value  out  DATA_WIDTH  that magnitude (raw)
peak_stb  out  1  one-cycle pulse when peak_band/peak_value update
drop_cnt  out  8  saturating count of dropped frame strobes
busy  out  1  high when state != IDLE

Behaviour:
- Reset (async, rst_n=0): state=IDLE; all outputs 0; pending=0; internal address=0; running max=0.
- pending flag:
  - Set by frame_stb when scan_en=1.
  - Cleared when a sweep starts from IDLE.
  - frame_stb with scan_en=1 while pending already set: drop_cnt++ (saturates at 255), pending stays 1.
  - frame_stb in the same cycle pending is cleared: pending ends at 1 (new strobe wins).
- FSM:
  - IDLE: if pending -> RD, addr=0, running max cleared (value 0, band 0).
  - RD: rd_en=1 and rd_addr=addr for exactly one cycle -> WAIT.
  - WAIT: on rd_data_valid, capture:
    - tdata = min(rd_data >> SHIFT, BAR_MAX), truncated to BAR_WIDTH;
    - tlast = (addr == BANDS-1);
    - if rd_data > running max (strict), update running max and band=addr; ties keep the lower index.
    - then assert m_axis_tvalid -> OUT.
    - rd_data_valid absent in WAIT is a protocol error: stay in WAIT.
  - OUT: tvalid, tdata and tlast held stable until the cycle tvalid & tready.
    - On handshake, tvalid drops next cycle (no back-to-back beats).
    - If addr == BANDS-1: peak_band/peak_value load the running max, peak_stb pulses for one cycle, -> IDLE.
    - Otherwise addr++ -> RD.
- Minimum throughput: 3 cycles per band with tready held 1.
- With tready held 1, a sweep takes 3*BANDS cycles from leaving IDLE (frame_stb-to-first-rd_en latency 2 cycles).
- frame_stb during a sweep only sets pending; the sweep in progress is never restarted. The next sweep begins on the cycle after return to IDLE.
- scan_en=0 clears nothing; a pending strobe still executes.
- rd_en never asserted outside RD; rd_addr holds its last value otherwise.
- Reset mid-sweep aborts immediately: tvalid=0, no tlast or peak_stb emitted.

Test Plan:
- Buffer holds band k = k*1024, tready=1, one frame_stb -> 32 beats, tdata 0,1,...,31 (all below BAR_MAX). tlast only on beat 31. peak_band=31, peak_value=31744, one peak_stb. First rd_en 2 cycles after frame_stb.
- Band 5 = 65535, others 100 -> beat 5 tdata=47 (saturated), others 0. peak_band=5, peak_value=65535.
- tready toggled randomly (~50%) -> tdata/tlast stable while tvalid & !tready, no beat lost or duplicated, exactly 32 beats.
- Three frame_stb pulses during one sweep -> exactly one extra sweep follows, drop_cnt=2. 300 such overruns -> drop_cnt sticks at 255.
- scan_en=0 with frame_stb -> no rd_en, busy stays 0. Strobe during a sweep, then scan_en=0 -> the pending sweep still runs.
- rst_n pulsed low at band 10 of a sweep -> all outputs 0 immediately. A following frame_stb produces a clean full 32-beat sweep starting at addr 0.
